// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU, one quotient bit per cycle.
// Define DIV_SIGNED_EN to support signed DIV; otherwise every op runs unsigned.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic                 annul_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 stall_o,
  output logic [1:0]           dbg_state_o
);

  // Handshake: EX holds start_i (with stable operands) until it sees ready_o;
  // ready_o stays high with result_o stable until start_i drops, and stall_o
  // holds the pipeline for every cycle a request is pending without a result.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZERO = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state;
  logic [5:0]           cnt;
  logic [2*WIDTH:0]     work;
  logic [WIDTH-1:0]     divisor_q;

  logic [2*WIDTH:0]     shifted;
  logic [WIDTH+1:0]     trial;
  logic [2*WIDTH:0]     step;
  logic [WIDTH-1:0]     quot_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH-1:0]     abs_dividend;
  logic [WIDTH-1:0]     abs_divisor;

  // work[2*WIDTH] is always 0 after a step because the remainder stays below the divisor.
  logic                 unused_bits;

`ifdef DIV_SIGNED_EN
  logic                 neg_quot_q;
  logic                 neg_rem_q;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic en);
    return (en && v[WIDTH-1]) ? -v : v;
  endfunction

  assign abs_dividend = abs_val(opdata1_i, signed_i);
  assign abs_divisor  = abs_val(opdata2_i, signed_i);
  assign quot_fix     = neg_quot_q ? -step[WIDTH-1:0]       : step[WIDTH-1:0];
  assign rem_fix      = neg_rem_q  ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
  assign unused_bits  = work[2*WIDTH];
`else
  assign abs_dividend = opdata1_i;
  assign abs_divisor  = opdata2_i;
  assign quot_fix     = step[WIDTH-1:0];
  assign rem_fix      = step[2*WIDTH-1:WIDTH];
  assign unused_bits  = work[2*WIDTH] ^ signed_i;
`endif

  // One restoring iteration: shift, trial-subtract the divisor from the upper half.
  always_comb begin
    shifted = {work[2*WIDTH-1:0], 1'b0};
    trial   = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, divisor_q};
    if (!trial[WIDTH+1]) begin
      step = {trial[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
    end else begin
      step = shifted;
    end
  end

  assign stall_o     = start_i & ~ready_o;
  assign dbg_state_o = state;

  always_ff @(posedge clk) begin
    if (rst || annul_i) begin
      state     <= IDLE;
      cnt       <= 6'd0;
      work      <= '0;
      divisor_q <= '0;
      result_o  <= '0;
      ready_o   <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ready_o <= 1'b0;
          if (start_i) begin
            if (opdata2_i == '0) begin
              state <= ZERO;
            end else begin
              state     <= BUSY;
              cnt       <= 6'd0;
              work      <= {{(WIDTH+1){1'b0}}, abs_dividend};
              divisor_q <= abs_divisor;
`ifdef DIV_SIGNED_EN
              neg_quot_q <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              neg_rem_q  <= signed_i & opdata1_i[WIDTH-1];
`endif
            end
          end
        end
        ZERO: begin
          state    <= DONE;
          result_o <= '0;
        end
        BUSY: begin
          work <= step;
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state    <= DONE;
            result_o <= {rem_fix, quot_fix};
          end
        end
        DONE: begin
          // ready_o follows DONE by one registered cycle, so it rises after entry.
          if (start_i) begin
            ready_o <= 1'b1;
          end else begin
            state   <= IDLE;
            ready_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: latency, results, divide-by-zero,
// annul and mid-operation reset. Expected values are hand-computed.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic        annul_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;
  logic [1:0]  dbg_state_o;

  logic [63:0] exp_q[$];
  int          n_checks;
  int          n_pass;

  div_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .annul_i     (annul_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .stall_o     (stall_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // drive a request at the negedge and return just after the accepting edge E0
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    @(negedge clk);
    start_i   = 1'b1;
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    @(posedge clk);
    #1;
  endtask

  // count edges after E0 until ready, then check the result and the release
  task automatic wait_result(input int exp_lat, input string tag);
    int          n;
    logic        prev_stall;
    logic [63:0] exp;
    n = 0;
    prev_stall = stall_o;
    while (!ready_o && n < 100) begin
      prev_stall = stall_o;
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else exp = 64'hDEAD_DEAD_DEAD_DEAD;
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " stall before ready"}, 64'(prev_stall), 64'd1);
    check({tag, " stall in ready cycle"}, 64'(stall_o), 64'd0);
    check({tag, " result"}, result_o, exp);
    @(posedge clk);
    #1;
    check({tag, " ready held"}, 64'(ready_o), 64'd1);
    check({tag, " result held"}, result_o, exp);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " ready drop"}, 64'(ready_o), 64'd0);
    check({tag, " back to idle"}, 64'(dbg_state_o), 64'd0);
  endtask

  initial begin
    int ready_seen;
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    start_i   = 1'b0;
    signed_i  = 1'b0;
    annul_i   = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    check("reset state", 64'(dbg_state_o), 64'd0);
    check("reset stall idle", 64'(stall_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // DIVU 100 / 7 = 14 r 2
    exp_q.push_back({32'd2, 32'd14});
    issue(32'd100, 32'd7, 1'b0);
    wait_result(33, "divu_100_7");

    // DIV -7 / 2
`ifdef DIV_SIGNED_EN
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
`else
    exp_q.push_back({32'h0000_0001, 32'h7FFF_FFFC});
`endif
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_result(33, "div_m7_2");

    // DIV 0x80000000 / 0xFFFFFFFF overflow case
`ifdef DIV_SIGNED_EN
    exp_q.push_back({32'h0000_0000, 32'h8000_0000});
`else
    exp_q.push_back({32'h8000_0000, 32'h0000_0000});
`endif
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_result(33, "div_ovf");

    // annul at BUSY iteration 10
    issue(32'd12345, 32'd11, 1'b0);
    ready_seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (ready_o) ready_seen++;
    end
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul state", 64'(dbg_state_o), 64'd0);
    check("annul ready", 64'(ready_o), 64'd0);
    check("annul result", result_o, 64'd0);
    check("annul no ready", 64'(ready_seen), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;

    // 9 / 3 after annul
    exp_q.push_back({32'd0, 32'd3});
    issue(32'd9, 32'd3, 1'b0);
    wait_result(33, "divu_9_3");

    // reset at BUSY iteration 20, start held so the op restarts
    issue(32'd1000, 32'd10, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst ready", 64'(ready_o), 64'd0);
    check("midrst result", result_o, 64'd0);
    check("midrst state", 64'(dbg_state_o), 64'd0);
    check("midrst stall", 64'(stall_o), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back({32'd0, 32'd100});
    wait_result(33, "divu_1000_10");

    // DIVU 5 / 0
    exp_q.push_back(64'h0);
    issue(32'd5, 32'd0, 1'b0);
    wait_result(2, "divu_5_0");

    check("queue empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative 32-bit divider sequencer for the MIPS execute stage, serving the DIV/DIVU ops whose results land in HI/LO. It accepts a request from EX, stalls the pipeline while a radix-2 restoring division runs one quotient bit per cycle, and returns the {remainder, quotient} pair for the HI/LO write. It also covers divide-by-zero and annulment on flush.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Only 32 is supported.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  divide request. Held high by EX until `ready_o` is seen.
- `signed_i`  in  1  1 selects DIV, 0 selects DIVU. Sampled when the request is accepted.
- `annul_i`  in  1  flush. Abandons any operation in progress.
- `opdata1_i`  in  32  dividend. Sampled when the request is accepted.
- `opdata2_i`  in  32  divisor. Sampled when the request is accepted.
- `result_o`  out  64  {remainder[63:32] → HI, quotient[31:0] → LO}.
- `ready_o`  out  1  result valid.
- `stall_o`  out  1  pipeline stall request. Combinational: `start_i & ~ready_o`.

## Operation
- States:
  - IDLE: waits for a request.
  - ZERO: divisor-zero result, one cycle.
  - BUSY: 32 iterations.
  - DONE: result held.
- IDLE:
  - `start_i & ~annul_i` and divisor 0 → ZERO.
  - `start_i & ~annul_i` and divisor nonzero → BUSY. On entry: operands latched, counter cleared, 65-bit work register = {33'b0, |dividend|}.
- BUSY, each cycle:
  - Shift the work register left by 1.
  - Trial-subtract |divisor| from bits [64:32].
  - Non-negative trial: keep the difference, set bit 0.
  - Negative trial: restore, clear bit 0.
  - Counter increments. After the 32nd iteration → DONE.
- ZERO → DONE, with result 64'h0.
- DONE:
  - `ready_o`=1 and `result_o` is stable.
  - Stays in DONE while `start_i`=1.
  - Returns to IDLE on the first cycle `start_i`=0.
- Sign fix-up, applied when loading `result_o` at the BUSY→DONE transition, only for signed ops:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Unsigned ops: absolute value is the identity; no fix-up.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): quotient 0x80000000, remainder 0. No exception.
- `annul_i`:
  - In any state → IDLE at the next edge, with `ready_o`=0 and `result_o` cleared.
  - Takes priority over completion and over a new start.

## Timing
- Reset values: state IDLE, `ready_o`=0, `result_o`=64'h0, counter 0. `stall_o` then follows `start_i`.
- Reset mid-operation: state and outputs return to the reset values at the next edge; any partial result is discarded.
- Nonzero divisor: request sampled at edge E0, `ready_o` rises after edge E0+33. `stall_o` is high for 34 cycles including the request cycle.
- Zero divisor: `ready_o` rises after edge E0+2.
- `ready_o` and `result_o` are registered. `result_o` changes only on entry to DONE, on reset, or on annul.
- Back-to-back: after DONE→IDLE, a new `start_i` is accepted no earlier than the cycle following the IDLE entry.

## Configuration
- `DIV_SIGNED_EN`:
  - Defined: signed DIV supported as above.
  - Undefined:
    - `signed_i` is ignored and every op runs unsigned.
    - Absolute-value and fix-up logic is removed.
    - Latency is unchanged.

## Test plan
- DIVU 100 / 7: `result_o`={32'd2, 32'd14}. `ready_o` high exactly 33 cycles after acceptance. `stall_o` drops in the ready cycle.
- DIV −7 / 2 (0xFFFFFFF9 / 2), `DIV_SIGNED_EN` defined: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. With the macro undefined: quotient 0x7FFFFFFC, remainder 1.
- DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- DIVU 5 / 0: `ready_o` after 2 cycles, `result_o`=64'h0.
- `annul_i` pulsed at BUSY iteration 10: state IDLE next cycle, `ready_o` never asserts. A new request (9 / 3) then completes correctly with quotient 3, remainder 0.
- `rst` asserted at BUSY iteration 20: outputs 0 next cycle. Holding `start_i` restarts the operation from the beginning with the full 33-cycle latency.
